// File: rtl/x_uart_tx_arb_if.sv
// Purpose: request/transmit handshake bundle for x_uart_tx_arb.
// Signals:
//   i_req_valid / i_req_data / i_req_last : per-requester byte offer (requester k uses data[8k+7:8k])
//   o_req_accept                          : one-cycle capture pulse back to the requester
//   o_tx_data / o_tx_valid                : byte presented to the UART transmitter
//   i_tx_accept                           : transmitter end-of-frame pulse
// Modports: master = requesters + transmitter side, slave = arbiter side.
interface x_uart_tx_arb_if #(
  parameter int unsigned p_n = 4
);
  logic [p_n-1:0]   i_req_valid;
  logic [8*p_n-1:0] i_req_data;
  logic [p_n-1:0]   i_req_last;
  logic [p_n-1:0]   o_req_accept;
  logic [7:0]       o_tx_data;
  logic             o_tx_valid;
  logic             i_tx_accept;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_accept,
    input  o_req_accept, o_tx_data, o_tx_valid
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_accept,
    output o_req_accept, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/x_uart_tx_arb.sv
// Purpose: round-robin arbiter sharing one UART transmitter between p_n byte
// sources. Multi-byte messages lock the line to their owner until the last
// byte; a lock idle for p_lock_timeout cycles is released.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : requester handshakes and transmitter handshake
//   o_busy         : arbiter is in SEND or LOCK
//   o_owner        : current / most recently granted requester
//   o_timeout      : one-cycle pulse when a lock is dropped by timeout
module x_uart_tx_arb #(
  parameter int unsigned p_n            = 4,
  parameter int unsigned p_lock_timeout = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  x_uart_tx_arb_if.slave         bus,
  output logic                   o_busy,
  output logic [$clog2(p_n)-1:0] o_owner,
  output logic                   o_timeout
);

  localparam int unsigned lp_ow = $clog2(p_n);
  localparam int unsigned lp_tw = (p_lock_timeout > 1) ? $clog2(p_lock_timeout) : 1;
  localparam logic [lp_tw-1:0] lp_tmax = lp_tw'(p_lock_timeout - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [lp_ow-1:0]   ptr_q, ptr_d;
  logic [lp_ow-1:0]   owner_q, owner_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic [lp_tw-1:0]   timer_q, timer_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;

  logic               rr_found;
  logic [lp_ow-1:0]   rr_win;
  logic [lp_ow:0]     rr_sum;
  logic [lp_ow-1:0]   cap_idx;
  logic               cap_valid;
  logic [7:0]         cap_data;
  logic               cap_last;
  logic [lp_ow-1:0]   next_owner;
  logic [p_n-1:0]     accept_c;
  logic               timeout_c;

  // First valid requester searching ptr, ptr+1, ... modulo p_n.
  always_comb begin : rr_search
    rr_found = 1'b0;
    rr_win   = '0;
    rr_sum   = '0;
    for (int i = 0; i < int'(p_n); i++) begin
      rr_sum = {1'b0, ptr_q} + (lp_ow+1)'(i);
      if (rr_sum >= (lp_ow+1)'(p_n)) begin
        rr_sum = rr_sum - (lp_ow+1)'(p_n);
      end
      if (!rr_found && bus.i_req_valid[rr_sum[lp_ow-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = rr_sum[lp_ow-1:0];
      end
    end
  end

  // Select the candidate's byte: round-robin winner in IDLE, the owner in LOCK.
  always_comb begin : cap_mux
    cap_idx   = (state_q == ST_LOCK) ? owner_q : rr_win;
    cap_valid = 1'b0;
    cap_data  = '0;
    cap_last  = 1'b0;
    for (int k = 0; k < int'(p_n); k++) begin
      if (cap_idx == lp_ow'(k)) begin
        cap_valid = bus.i_req_valid[k];
        cap_data  = bus.i_req_data[8*k +: 8];
        cap_last  = bus.i_req_last[k];
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin : fsm_next
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    data_d     = data_q;
    last_d     = last_q;
    timer_d    = timer_q;
    accept_c   = '0;
    timeout_c  = 1'b0;
    next_owner = (owner_q == lp_ow'(p_n - 1)) ? '0 : owner_q + lp_ow'(1);

    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          accept_c = p_n'(1) << rr_win;
          data_d   = cap_data;
          last_d   = cap_last;
          owner_d  = rr_win;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.i_tx_accept) begin
          if (last_q) begin
            ptr_d   = next_owner;
            state_d = ST_IDLE;
          end else begin
            timer_d = '0;
            state_d = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        // A byte arriving on the final timer cycle still wins over the timeout.
        if (cap_valid) begin
          accept_c = p_n'(1) << owner_q;
          data_d   = cap_data;
          last_d   = cap_last;
          state_d  = ST_SEND;
        end else if (timer_q == lp_tmax) begin
          ptr_d     = next_owner;
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + lp_tw'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tx_valid_d = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and holding registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      timer_q    <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      data_q     <= data_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_req_accept = accept_c;
  assign bus.o_tx_data    = data_q;
  assign bus.o_tx_valid   = tx_valid_q;
  assign o_busy           = busy_q;
  assign o_owner          = owner_q;
  assign o_timeout        = timeout_c;

endmodule

// File: tb/tb_x_uart_tx_arb.sv
// Purpose: directed bench for x_uart_tx_arb with per-requester source queues,
// a transmitter model and a scoreboard of expected {owner, byte} line order.
module tb_x_uart_tx_arb;

  localparam int unsigned P_N  = 4;
  localparam int unsigned P_TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  x_uart_tx_arb_if #(.p_n(P_N)) bus ();
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  x_uart_tx_arb #(.p_n(P_N), .p_lock_timeout(P_TO)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus.slave),
    .o_busy    (busy),
    .o_owner   (owner),
    .o_timeout (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]     src_q [P_N][$];   // {last, data} per requester
  logic [9:0]     sb_q [$];         // expected {owner, data} in line order
  logic [P_N-1:0] acc_seen = '0;
  int             tx_dly = 2;
  bit             tx_en  = 1'b1;
  int             timeout_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Requesters: present the head of each queue, pop after a seen accept.
  initial begin
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < int'(P_N); k++) begin
        if (acc_seen[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          bus.i_req_valid[k]       = 1'b1;
          bus.i_req_data[8*k +: 8] = src_q[k][0][7:0];
          bus.i_req_last[k]        = src_q[k][0][8];
        end else begin
          bus.i_req_valid[k] = 1'b0;
        end
      end
    end
  end

  // Transmitter: end-of-frame pulse after tx_dly cycles of o_tx_valid.
  initial begin
    int cnt;
    cnt = 0;
    bus.i_tx_accept = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_tx_accept = 1'b0;
      if (tx_en && bus.o_tx_valid) begin
        cnt++;
        if (cnt >= tx_dly) begin
          bus.i_tx_accept = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: handshake rules, latencies, data stability and scoreboard.
  initial begin
    logic       prev_valid, prev_acc, prev_txacc;
    logic [7:0] prev_data;
    logic [9:0] exp;
    prev_valid = 1'b0; prev_acc = 1'b0; prev_txacc = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      acc_seen = bus.o_req_accept;
      if (timeout) timeout_cnt++;
      if (!rst_n) begin
        prev_valid = 1'b0; prev_acc = 1'b0; prev_txacc = 1'b0;
      end else begin
        chk("accept_onehot", 32'($onehot0(bus.o_req_accept)), 32'd1);
        chk("accept_needs_valid", 32'(bus.o_req_accept & ~bus.i_req_valid), 32'd0);
        if (prev_acc) chk("accept_to_tx_valid", 32'(bus.o_tx_valid), 32'd1);
        if (prev_txacc && prev_valid) chk("tx_accept_to_low", 32'(bus.o_tx_valid), 32'd0);
        if (prev_valid && bus.o_tx_valid) chk("tx_data_stable", 32'(bus.o_tx_data), 32'(prev_data));
        if (bus.o_tx_valid && !prev_valid) begin
          chk("sb_pending", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk("tx_owner_byte", 32'({owner, bus.o_tx_data}), 32'(exp));
          end
        end
        prev_valid = bus.o_tx_valid;
        prev_acc   = |bus.o_req_accept;
        prev_txacc = bus.i_tx_accept;
        prev_data  = bus.o_tx_data;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    for (int k = 0; k < int'(P_N); k++) src_q[k].delete();
    sb_q.delete();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_accept(input int k, input string tag);
    int n;
    n = 0;
    while (bus.o_req_accept[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_txv(input logic v, input string tag);
    int n;
    n = 0;
    while (bus.o_tx_valid !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int  n;
    bool_loop: begin end
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
          src_q[3].size() == 0 && sb_q.size() == 0 && !busy && !bus.o_tx_valid) break;
    end
    chk(tag, 32'(n < 600), 32'd1);
  endtask

  // Directed scenarios.
  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
    chk("rst_tx_data",  32'(bus.o_tx_data),  32'd0);
    chk("rst_busy",     32'(busy),           32'd0);
    chk("rst_owner",    32'(owner),          32'd0);
    chk("rst_timeout",  32'(timeout),        32'd0);
    rst_n = 1'b1;

    // Single byte from requester 1, then pointer check (ptr=2 favours 3 over 1).
    tx_dly = 2;
    src_q[1].push_back({1'b1, 8'h5A}); sb_q.push_back({2'd1, 8'h5A});
    wait_accept(1, "single_accept_seen");
    @(negedge clk);
    chk("single_tx_valid", 32'(bus.o_tx_valid), 32'd1);
    chk("single_tx_data",  32'(bus.o_tx_data),  32'h5A);
    wait_txv(1'b0, "single_tx_done");
    chk("single_owner", 32'(owner), 32'd1);
    chk("single_idle",  32'(busy),  32'd0);
    src_q[1].push_back({1'b1, 8'h5B});
    src_q[3].push_back({1'b1, 8'h5C});
    sb_q.push_back({2'd3, 8'h5C}); sb_q.push_back({2'd1, 8'h5B});
    wait_idle("ptr_idle");

    // Fairness: all requesters valid, grant order 0,1,2,3,0.
    do_reset();
    tx_dly = 10;
    src_q[0].push_back({1'b1, 8'hA0}); src_q[0].push_back({1'b1, 8'hB0});
    src_q[1].push_back({1'b1, 8'hA1});
    src_q[2].push_back({1'b1, 8'hA2});
    src_q[3].push_back({1'b1, 8'hA3});
    sb_q.push_back({2'd0, 8'hA0}); sb_q.push_back({2'd1, 8'hA1});
    sb_q.push_back({2'd2, 8'hA2}); sb_q.push_back({2'd3, 8'hA3});
    sb_q.push_back({2'd0, 8'hB0});
    wait_idle("fair_idle");

    // Message lock: requester 0 keeps the line until its last byte.
    do_reset();
    tx_dly = 3;
    src_q[0].push_back({1'b0, 8'h11}); src_q[0].push_back({1'b0, 8'h22});
    src_q[0].push_back({1'b1, 8'h33});
    src_q[2].push_back({1'b1, 8'h77});
    sb_q.push_back({2'd0, 8'h11}); sb_q.push_back({2'd0, 8'h22});
    sb_q.push_back({2'd0, 8'h33}); sb_q.push_back({2'd2, 8'h77});
    wait_idle("lock_idle");
    #1 chk("lock_no_timeout", 32'(timeout_cnt), 32'd0);

    // Lock timeout: owner 3 goes quiet, requester 0 waits.
    do_reset();
    tx_dly = 2;
    src_q[3].push_back({1'b0, 8'h44}); sb_q.push_back({2'd3, 8'h44});
    wait_accept(3, "to_accept_seen");
    src_q[0].push_back({1'b1, 8'h55}); sb_q.push_back({2'd0, 8'h55});
    wait_txv(1'b1, "to_tx_up");
    wait_txv(1'b0, "to_tx_down");
    n = 1;
    while (!timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_lock_cycles", 32'(n), 32'd8);
    chk("to_busy_in_lock", 32'(busy), 32'd1);
    @(negedge clk);
    chk("to_grant_req0", 32'(bus.o_req_accept), 32'b0001);
    chk("to_idle", 32'(busy), 32'd0);
    wait_idle("to_idle_end");
    #1 chk("to_pulse_count", 32'(timeout_cnt), 32'd1);

    // Owner becomes valid exactly on the last timer cycle: capture wins.
    do_reset();
    src_q[3].push_back({1'b0, 8'h44}); sb_q.push_back({2'd3, 8'h44});
    wait_txv(1'b1, "co_tx_up");
    wait_txv(1'b0, "co_tx_down");
    n = 1;
    while (n < 7) begin
      @(negedge clk);
      n++;
    end
    src_q[3].push_back({1'b1, 8'h66}); sb_q.push_back({2'd3, 8'h66});
    @(negedge clk);
    chk("co_accept", 32'(bus.o_req_accept), 32'b1000);
    chk("co_no_timeout", 32'(timeout), 32'd0);
    wait_idle("co_idle");
    #1 chk("co_pulse_count", 32'(timeout_cnt), 32'd1);

    // Reset in the middle of SEND.
    do_reset();
    tx_en = 1'b0;
    src_q[2].push_back({1'b1, 8'hA5}); sb_q.push_back({2'd2, 8'hA5});
    wait_txv(1'b1, "rs_tx_up");
    @(negedge clk);
    chk("rs_owner_before", 32'(owner), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_tx_valid", 32'(bus.o_tx_valid), 32'd0);
    chk("rs_busy",     32'(busy),           32'd0);
    chk("rs_owner",    32'(owner),          32'd0);
    chk("rs_tx_data",  32'(bus.o_tx_data),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rs_no_accept", 32'(bus.o_req_accept), 32'd0);
      chk("rs_no_resend", 32'(bus.o_tx_valid),   32'd0);
    end
    tx_en = 1'b1;
    src_q[1].push_back({1'b1, 8'hC3}); sb_q.push_back({2'd1, 8'hC3});
    wait_idle("rs_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no completion, expected finish before 300000");
    $fatal(1, "watchdog expired");
  end

endmodule
